lsu: RTL and testbench

Load/store unit sitting between the core's execute stage and `dcache`. It acts as the initiator of the dcache request/valid protocol. It accepts one memory operation at a time from the pipeline and converts RV32I load/store widths into a word-aligned address, `byte_enable` mask and lane-replicated `wdata`. It then holds the request until `dcache` answers, and returns sign/zero-extended load data or an error code to the pipeline.

---
 rtl/lsu.sv | 201 ++++++++++++++++++++
 tb/tb_lsu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: turns one RV32I load/store at a time into a single
// word-aligned dcache request, waits for the matching completion or a
// timeout, then returns extended load data or an error code.
module lsu #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] addr,
    output logic        wreq,
    output logic        rreq,
    output logic [31:0] wdata,
    output logic [3:0]  byte_enable,
    input  logic        wvalid,
    input  logic [31:0] rdata,
    input  logic        rvalid
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic          op_we, op_we_next;
    logic [2:0]    op_funct3, op_funct3_next;
    logic [1:0]    op_off, op_off_next;

    logic          req_ready_next, resp_valid_next, wreq_next, rreq_next;
    logic [31:0]   resp_rdata_next, addr_next, wdata_next;
    logic [1:0]    resp_err_next;
    logic [3:0]    byte_enable_next;

    logic          illegal;
    logic [3:0]    be_enc;
    logic [31:0]   wdata_enc;

    // Shift the addressed lane down to bit 0 and extend it per the load width.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Decode the incoming request: legality, lane mask and replicated store data.
    always_comb begin
        illegal   = 1'b1;
        be_enc    = 4'b1111;
        wdata_enc = req_wdata;
        case (req_funct3)
            3'd0:    illegal = 1'b0;
            3'd1:    illegal = req_addr[0];
            3'd2:    illegal = |req_addr[1:0];
            3'd4:    illegal = req_we;
            3'd5:    illegal = req_we | req_addr[0];
            default: illegal = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'd0: begin
                be_enc    = 4'b0001 << req_addr[1:0];
                wdata_enc = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_enc    = 4'b0011 << req_addr[1:0];
                wdata_enc = {2{req_wdata[15:0]}};
            end
            default: begin
                be_enc    = 4'b1111;
                wdata_enc = req_wdata;
            end
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next       = state;
        timer_next       = timer;
        op_we_next       = op_we;
        op_funct3_next   = op_funct3;
        op_off_next      = op_off;
        resp_valid_next  = 1'b0;
        resp_rdata_next  = resp_rdata;
        resp_err_next    = resp_err;
        addr_next        = addr;
        wdata_next       = wdata;
        byte_enable_next = byte_enable;
        wreq_next        = wreq;
        rreq_next        = rreq;

        case (state)
            IDLE: begin
                resp_rdata_next = 32'd0;
                resp_err_next   = ERR_OK;
                if (req_valid) begin
                    op_we_next     = req_we;
                    op_funct3_next = req_funct3;
                    op_off_next    = req_addr[1:0];
                    if (illegal) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = ERR_ALIGN;
                    end else begin
                        state_next       = ACCESS;
                        timer_next       = '0;
                        addr_next        = {req_addr[31:2], 2'b00};
                        byte_enable_next = be_enc;
                        wdata_next       = req_we ? wdata_enc : 32'd0;
                        wreq_next        = req_we;
                        rreq_next        = ~req_we;
                    end
                end
            end
            ACCESS: begin
                if (op_we ? wvalid : rvalid) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = ERR_OK;
                    resp_rdata_next = op_we ? 32'd0 : extract(op_funct3, op_off, rdata);
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_err_next   = ERR_TIMEOUT;
                    resp_rdata_next = 32'd0;
                end else begin
                    timer_next = timer + 1'b1;
                end
                if (state_next == RESP) begin
                    wreq_next        = 1'b0;
                    rreq_next        = 1'b0;
                    addr_next        = 32'd0;
                    wdata_next       = 32'd0;
                    byte_enable_next = 4'd0;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        req_ready_next = (state_next == IDLE);
    end

    // State, operation and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state       <= IDLE;
            timer       <= '0;
            op_we       <= 1'b0;
            op_funct3   <= 3'd0;
            op_off      <= 2'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_err    <= ERR_OK;
            addr        <= 32'd0;
            wdata       <= 32'd0;
            byte_enable <= 4'd0;
            wreq        <= 1'b0;
            rreq        <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            op_we       <= op_we_next;
            op_funct3   <= op_funct3_next;
            op_off      <= op_off_next;
            req_ready   <= req_ready_next;
            resp_valid  <= resp_valid_next;
            resp_rdata  <= resp_rdata_next;
            resp_err    <= resp_err_next;
            addr        <= addr_next;
            wdata       <= wdata_next;
            byte_enable <= byte_enable_next;
            wreq        <= wreq_next;
            rreq        <= rreq_next;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios from the feature list plus
// randomized operations checked against a behavioural model.
module tb_lsu;

    localparam int TO   = 8;
    localparam int LOOP = TO + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] addr, wdata, rdata;
    logic        wreq, rreq, wvalid, rvalid;
    logic [3:0]  byte_enable;

    int vectors     = 0;
    int miscompares = 0;

    // Observations from one operation.
    int          o_wreq, o_rreq, o_resp_cnt, o_resp_cyc;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic [1:0]  o_err;
    logic        o_stable, o_ready_before, o_ready_after;

    // Model expectations for one operation.
    int          e_acc, e_resp_cyc;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic [1:0]  e_err;

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .addr(addr), .wreq(wreq), .rreq(rreq), .wdata(wdata),
        .byte_enable(byte_enable), .wvalid(wvalid), .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    // Behavioural model: derives the whole transaction from width/offset arithmetic.
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int delay, input logic [31:0] rd);
        int          size, off;
        logic [31:0] m, v;
        logic        bad;
        off  = int'(a % 4);
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        bad  = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4) || (a % size != 0);
        m    = (size == 4) ? 32'hffff_ffff : ((32'd1 << (8 * size)) - 32'd1);
        e_addr  = a - 32'(off);
        e_be    = 4'(((1 << size) - 1) << off);
        e_wdata = 32'd0;
        if (we)
            for (int i = 0; i < 4 / size; i++)
                e_wdata = e_wdata | ((d & m) << (8 * size * i));
        v = (rd >> (8 * off)) & m;
        if (f3 < 4 && size < 4 && v[8*size-1]) v = v | ~m;
        if (bad) begin
            e_acc = 0; e_err = 2'b01; e_rdata = 32'd0; e_resp_cyc = 1;
        end else if (delay < TO) begin
            e_acc = delay + 1; e_err = 2'b00; e_rdata = we ? 32'd0 : v;
            e_resp_cyc = delay + 2;
        end else begin
            e_acc = TO; e_err = 2'b10; e_rdata = 32'd0; e_resp_cyc = TO + 1;
        end
    endtask

    // Issue one request and play dcache for a fixed window, recording what the DUT did.
    // The matching valid arrives in access cycle delay+1; wrong drives the other
    // valid every cycle; stray re-asserts the matching valid one cycle late.
    task automatic drive_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int delay, input logic [31:0] rd,
                            input logic wrong, input logic stray);
        logic match;
        @(negedge clk);
        o_ready_before = req_ready;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        o_wreq = 0; o_rreq = 0; o_resp_cnt = 0; o_resp_cyc = 0; o_stable = 1'b1;
        o_addr = '0; o_wdata = '0; o_be = '0; o_err = '0; o_rdata = '0;
        for (int c = 1; c <= LOOP; c++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            if (wreq || rreq) begin
                if (o_wreq + o_rreq == 0) begin
                    o_addr = addr; o_wdata = wdata; o_be = byte_enable;
                end else if (addr !== o_addr || wdata !== o_wdata || byte_enable !== o_be) begin
                    o_stable = 1'b0;
                end
                if (wreq) o_wreq++;
                if (rreq) o_rreq++;
            end
            if (resp_valid) begin
                o_resp_cnt++; o_resp_cyc = c; o_err = resp_err; o_rdata = resp_rdata;
            end
            match  = (c == delay + 1) || (stray && c == delay + 2);
            wvalid = we ? match : wrong;
            rvalid = we ? wrong : match;
            rdata  = (!we && c == delay + 1) ? rd : $urandom;
        end
        o_ready_after = req_ready;
        @(negedge clk);
        wvalid = 1'b0; rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        wvalid = 0; rvalid = 0; rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
        vectors++;
        if ({resp_valid, wreq, rreq, resp_err} !== 5'd0) begin
            miscompares++; $display("FAIL reset ctrl: got %b want 00000", {resp_valid, wreq, rreq, resp_err});
        end
        vectors++;
        if ({addr, wdata, resp_rdata, byte_enable} !== 100'd0) begin
            miscompares++; $display("FAIL reset data: addr %h wdata %h rdata %h be %b want all 0",
                                    addr, wdata, resp_rdata, byte_enable);
        end
        rst = 1'b1;
    endtask

    task automatic test_sb();
        drive_op(1'b1, 3'd0, 32'h6, 32'h1234_56ff, 0, 32'd0, 1'b0, 1'b0);
        vectors++;
        if ({o_addr, o_be, o_wdata} !== {32'h4, 4'b0100, 32'hffff_ffff}) begin
            miscompares++; $display("FAIL sb encode: got addr %h be %b wdata %h want 4 0100 ffffffff",
                                    o_addr, o_be, o_wdata);
        end
        vectors++;
        if (o_wreq !== 1 || o_rreq !== 0) begin
            miscompares++; $display("FAIL sb req: got wreq %0d rreq %0d want 1 0", o_wreq, o_rreq);
        end
        vectors++;
        if (o_resp_cyc !== 2 || o_err !== 2'b00 || o_resp_cnt !== 1) begin
            miscompares++; $display("FAIL sb resp: got cyc %0d err %b cnt %0d want 2 00 1",
                                    o_resp_cyc, o_err, o_resp_cnt);
        end
    endtask

    task automatic test_lb_lbu();
        drive_op(1'b0, 3'd0, 32'h5, 32'd0, 0, 32'h0000_a500, 1'b0, 1'b0);
        vectors++;
        if (o_rdata !== 32'hffff_ffa5) begin miscompares++; $display("FAIL lb data: got %h want ffffffa5", o_rdata); end
        vectors++;
        if (o_rreq !== 1 || o_be !== 4'b0010 || o_wdata !== 32'd0) begin
            miscompares++; $display("FAIL lb req: got rreq %0d be %b wdata %h want 1 0010 0", o_rreq, o_be, o_wdata);
        end
        drive_op(1'b0, 3'd4, 32'h5, 32'd0, 0, 32'h0000_a500, 1'b0, 1'b0);
        vectors++;
        if (o_rdata !== 32'h0000_00a5) begin miscompares++; $display("FAIL lbu data: got %h want 000000a5", o_rdata); end
    endtask

    task automatic test_wait_states();
        drive_op(1'b0, 3'd1, 32'h2, 32'd0, 5, 32'h8001_dead, 1'b0, 1'b0);
        vectors++;
        if (o_rreq !== 6 || o_stable !== 1'b1) begin
            miscompares++; $display("FAIL wait rreq: got cycles %0d stable %b want 6 1", o_rreq, o_stable);
        end
        vectors++;
        if (o_addr !== 32'h0 || o_be !== 4'b1100) begin
            miscompares++; $display("FAIL wait addr: got %h be %b want 0 1100", o_addr, o_be);
        end
        vectors++;
        if (o_rdata !== 32'hffff_8001 || o_resp_cyc !== 7) begin
            miscompares++; $display("FAIL wait resp: got %h cyc %0d want ffff8001 7", o_rdata, o_resp_cyc);
        end
    endtask

    task automatic test_illegal();
        logic        we_t [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  f3_t [3] = '{3'd2, 3'd1, 3'd4};
        logic [31:0] a_t  [3] = '{32'h2, 32'h3, 32'h8};
        for (int i = 0; i < 3; i++) begin
            drive_op(we_t[i], f3_t[i], a_t[i], 32'hdead_beef, 0, 32'hffff_ffff, 1'b0, 1'b1);
            vectors++;
            if (o_err !== 2'b01 || o_resp_cyc !== 1 || o_resp_cnt !== 1 || o_rdata !== 32'd0) begin
                miscompares++; $display("FAIL illegal%0d resp: got err %b cyc %0d cnt %0d rdata %h want 01 1 1 0",
                                        i, o_err, o_resp_cyc, o_resp_cnt, o_rdata);
            end
            vectors++;
            if (o_wreq !== 0 || o_rreq !== 0) begin
                miscompares++; $display("FAIL illegal%0d req: got wreq %0d rreq %0d want 0 0", i, o_wreq, o_rreq);
            end
        end
    endtask

    task automatic test_timeout();
        drive_op(1'b1, 3'd2, 32'h40, 32'h1111_2222, 100, 32'd0, 1'b0, 1'b0);
        vectors++;
        if (o_wreq !== TO) begin miscompares++; $display("FAIL timeout wreq: got %0d cycles want %0d", o_wreq, TO); end
        vectors++;
        if (o_err !== 2'b10 || o_rdata !== 32'd0 || o_resp_cyc !== TO + 1) begin
            miscompares++; $display("FAIL timeout resp: got err %b rdata %h cyc %0d want 10 0 %0d",
                                    o_err, o_rdata, o_resp_cyc, TO + 1);
        end
        drive_op(1'b1, 3'd2, 32'h8, 32'h3333_4444, 1, 32'd0, 1'b0, 1'b0);
        vectors++;
        if (o_ready_before !== 1'b1 || o_err !== 2'b00 || o_resp_cyc !== 3 || o_wdata !== 32'h3333_4444) begin
            miscompares++; $display("FAIL after timeout: got ready %b err %b cyc %0d wdata %h want 1 00 3 33334444",
                                    o_ready_before, o_err, o_resp_cyc, o_wdata);
        end
    endtask

    task automatic test_wrong_valid();
        drive_op(1'b1, 3'd2, 32'hc, 32'h5555_aaaa, 3, 32'd0, 1'b1, 1'b0);
        vectors++;
        if (o_wreq !== 4 || o_resp_cyc !== 5 || o_err !== 2'b00) begin
            miscompares++; $display("FAIL rvalid on store: got wreq %0d cyc %0d err %b want 4 5 00",
                                    o_wreq, o_resp_cyc, o_err);
        end
        drive_op(1'b0, 3'd2, 32'h10, 32'd0, 2, 32'hcafe_f00d, 1'b1, 1'b0);
        vectors++;
        if (o_rreq !== 3 || o_rdata !== 32'hcafe_f00d) begin
            miscompares++; $display("FAIL wvalid on load: got rreq %0d rdata %h want 3 cafef00d", o_rreq, o_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rreq !== 1'b1) begin miscompares++; $display("FAIL mid access rreq: got %b want 1", rreq); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rreq, wreq, resp_valid, req_ready} !== 4'b0001) begin
            miscompares++; $display("FAIL reset abandon: got rreq/wreq/resp_valid/ready %b want 0001",
                                    {rreq, wreq, resp_valid, req_ready});
        end
        rst = 1'b1;
        pulses = 0;
        rvalid = 1'b1; rdata = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rvalid = 1'b0;
            if (resp_valid || rreq || wreq) pulses++;
        end
        vectors++;
        if (pulses !== 0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL after reset: got activity %0d ready %b want 0 1", pulses, req_ready);
        end
    endtask

    task automatic test_random();
        logic        we, wrong, stray;
        logic [2:0]  f3;
        logic [31:0] a, d, rd;
        int          delay;
        for (int n = 0; n < 40; n++) begin
            we    = 1'($urandom);
            f3    = 3'($urandom_range(0, 7));
            a     = $urandom;
            d     = $urandom;
            rd    = $urandom;
            delay = $urandom_range(0, TO + 1);
            wrong = 1'($urandom);
            stray = 1'($urandom);
            model_op(we, f3, a, d, delay, rd);
            drive_op(we, f3, a, d, delay, rd, wrong, stray);
            vectors++;
            if (o_resp_cnt !== 1 || o_resp_cyc !== e_resp_cyc || o_err !== e_err) begin
                miscompares++; $display("FAIL rand%0d resp: got cnt %0d cyc %0d err %b want 1 %0d %b",
                                        n, o_resp_cnt, o_resp_cyc, o_err, e_resp_cyc, e_err);
            end
            vectors++;
            if (o_rdata !== e_rdata) begin
                miscompares++; $display("FAIL rand%0d rdata: got %h want %h", n, o_rdata, e_rdata);
            end
            vectors++;
            if (o_wreq !== (we ? e_acc : 0) || o_rreq !== (we ? 0 : e_acc)) begin
                miscompares++; $display("FAIL rand%0d req: got wreq %0d rreq %0d want %0d %0d",
                                        n, o_wreq, o_rreq, we ? e_acc : 0, we ? 0 : e_acc);
            end
            if (e_acc > 0) begin
                vectors++;
                if (o_addr !== e_addr || o_be !== e_be || o_wdata !== e_wdata || o_stable !== 1'b1) begin
                    miscompares++; $display("FAIL rand%0d bus: got addr %h be %b wdata %h stable %b want %h %b %h 1",
                                            n, o_addr, o_be, o_wdata, o_stable, e_addr, e_be, e_wdata);
                end
            end
            vectors++;
            if (o_ready_before !== 1'b1 || o_ready_after !== 1'b1) begin
                miscompares++; $display("FAIL rand%0d ready: got before %b after %b want 1 1",
                                        n, o_ready_before, o_ready_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_lb_lbu();
        test_wait_states();
        test_illegal();
        test_timeout();
        test_wrong_valid();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
